// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller:
// forwarding mux selects and divider sequencer states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/hazard_if.sv
// Datapath <-> hazard controller bundle: stage register
// indices/enables in, stall/flush/forward controls out.
interface hazard_if #(
  parameter int REGW = 5
);

  logic [REGW-1:0] rsD;
  logic [REGW-1:0] rtD;
  logic [REGW-1:0] rsE;
  logic [REGW-1:0] rtE;
  logic [REGW-1:0] writeregE;
  logic [REGW-1:0] writeregM;
  logic [REGW-1:0] writeregW;
  logic            regwriteE;
  logic            regwriteM;
  logic            regwriteW;
  logic            memtoregE;
  logic            memtoregM;
  logic            branchD;
  logic            jumpregD;
  logic            div_startE;
  logic            exceptM;

  logic            stallF;
  logic            stallD;
  logic            stallE;
  logic            flushD;
  logic            flushE;
  logic            flushM;
  logic            flushW;
  logic            forwardAD;
  logic            forwardBD;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;
  logic            div_doneE;
  logic            flush_pc;

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW,
    output memtoregE, memtoregM,
    output branchD, jumpregD,
    output div_startE, exceptM,
    input  stallF, stallD, stallE,
    input  flushD, flushE, flushM, flushW,
    input  forwardAD, forwardBD,
    input  forwardAE, forwardBE,
    input  div_doneE, flush_pc
  );

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW,
    input  memtoregE, memtoregM,
    input  branchD, jumpregD,
    input  div_startE, exceptM,
    output stallF, stallD, stallE,
    output flushD, flushE, flushM, flushW,
    output forwardAD, forwardBD,
    output forwardAE, forwardBE,
    output div_doneE, flush_pc
  );

endinterface

// File: rtl/div_stall_fsm.sv
// Divider stall sequencer: holds E for DIV_CYCLES cycles,
// then pulses div_done once; abort returns to idle.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic divstall,
  output logic div_done
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    divstall = 1'b0;
    div_done = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (start) begin
          divstall = 1'b1;
          cnt_n    = CNT_INIT;
          state_n  = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        divstall = 1'b1;
        cnt_n    = cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          state_n = DIV_DONE;
      end
      // Leave unconditionally so a held start cannot re-arm here
      DIV_DONE: begin
        div_done = 1'b1;
        state_n  = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
    if (abort) begin
      state_n = DIV_IDLE;
      cnt_n   = '0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: forwarding selects, load/branch
// interlocks, divider stall window and exception flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGW       = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  logic divstall;
  logic div_done;
  logic lwstall;
  logic brstall;
  logic sel_ex;
  logic sel_div;
  logic sel_hz;

  // $0 is hardwired, so it never creates a dependency
  function automatic logic hit(
    input logic [REGW-1:0] a,
    input logic [REGW-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (hz.div_startE),
    .abort    (hz.exceptM),
    .divstall (divstall),
    .div_done (div_done)
  );

  always_comb begin
    hz.forwardAE = FWD_RF;
    hz.forwardBE = FWD_RF;
    if (hz.regwriteM && hit(hz.writeregM, hz.rsE))
      hz.forwardAE = FWD_MEM;
    else if (hz.regwriteW && hit(hz.writeregW, hz.rsE))
      hz.forwardAE = FWD_WB;
    if (hz.regwriteM && hit(hz.writeregM, hz.rtE))
      hz.forwardBE = FWD_MEM;
    else if (hz.regwriteW && hit(hz.writeregW, hz.rtE))
      hz.forwardBE = FWD_WB;
  end

  assign hz.forwardAD = hz.regwriteM
                     && hit(hz.writeregM, hz.rsD);
  assign hz.forwardBD = hz.regwriteM
                     && hit(hz.writeregM, hz.rtD);

  assign lwstall = hz.memtoregE
                && (hit(hz.rtE, hz.rsD)
                 || hit(hz.rtE, hz.rtD));

  assign brstall = (hz.branchD || hz.jumpregD)
    && ((hz.regwriteE
         && (hit(hz.writeregE, hz.rsD)
          || hit(hz.writeregE, hz.rtD)))
     || (hz.memtoregM
         && (hit(hz.writeregM, hz.rsD)
          || hit(hz.writeregM, hz.rtD))));

  assign sel_ex  = rst_n && hz.exceptM;
  assign sel_div = rst_n && !hz.exceptM && divstall;
  assign sel_hz  = rst_n && !hz.exceptM && !divstall
                && (lwstall || brstall);

  assign hz.div_doneE = rst_n && !hz.exceptM && div_done;

  always_comb begin
    hz.stallF   = 1'b0;
    hz.stallD   = 1'b0;
    hz.stallE   = 1'b0;
    hz.flushD   = 1'b0;
    hz.flushE   = 1'b0;
    hz.flushM   = 1'b0;
    hz.flushW   = 1'b0;
    hz.flush_pc = 1'b0;
    unique case (1'b1)
      sel_ex: begin
        hz.flushD   = 1'b1;
        hz.flushE   = 1'b1;
        hz.flushM   = 1'b1;
        hz.flushW   = 1'b1;
        hz.flush_pc = 1'b1;
      end
      sel_div: begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.flushM = 1'b1;
      end
      sel_hz: begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
